// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial pattern transmitter
//
// Shifts a latched bit pattern (MSB first) onto x_out at a slow bit rate set by
// an internal divider (bit period = DIV_LIMIT+1 clk cycles). Each bit starts
// with a one-cycle bit_strobe. After a frame, x_out is held low for GAP_TICKS
// bit periods; the frame then repeats if rpt is high, else the block returns
// to IDLE and pulses done.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   level request to transmit; accepted only in IDLE
//   abort      in   cancels any transfer in progress (wins over start)
//   pattern    in   [PAT_W-1:0] bits to send, latched on start
//   len        in   [3:0] bits to send, latched on start, clamped to PAT_W
//   rpt        in   repeat enable, sampled at the end of each gap
//   x_out      out  serial data line
//   bit_strobe out  one-cycle pulse on the first clk of every transmitted bit
//   busy       out  high in SEND and GAP
//   done       out  one-cycle pulse when a non-repeated transfer ends normally
//   bit_idx    out  [3:0] index of the bit on x_out, 0 outside SEND
//   frame_cnt  out  [7:0] frames completed since the last accepted start
//   state_dbg  out  [1:0] current FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Request semantics: start is a level, not a handshake. It is acted on in any
// IDLE cycle where start=1, abort=0 and len!=0; in every other cycle it is
// ignored. abort is acted on in any SEND/GAP cycle and takes priority over
// every other event in that cycle, including the end of a frame.
// -----------------------------------------------------------------------------
module seq_gen #(
  parameter int PAT_W     = 8,
  parameter int DIV_LIMIT = 12500000,
  parameter int GAP_TICKS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  input  logic             rpt,
  output logic             x_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_idx,
  output logic [7:0]       frame_cnt,
  output logic [1:0]       state_dbg
);

  localparam int               DIV_W    = (DIV_LIMIT < 1) ? 1 : $clog2(DIV_LIMIT + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV_LIMIT);
  localparam logic [3:0]       PAT_W4   = 4'(PAT_W);
  localparam logic [3:0]       GAP_LAST = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       idx_d;
  logic [7:0]       frame_d;
  logic             x_d, strobe_d, busy_d, done_d;
  logic             tick;
  logic             frame_end;

  assign tick      = (div_q == DIV_MAX);
  assign state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    idx_d     = bit_idx;
    frame_d   = frame_cnt;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        idx_d = 4'd0;
        if (start && !abort && (len != 4'd0)) begin
          state_d  = SEND;
          shift_d  = pattern;
          pat_d    = pattern;
          len_d    = (len > PAT_W4) ? PAT_W4 : len;
          frame_d  = 8'd0;
          strobe_d = 1'b1;
        end
      end

      SEND: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if ((bit_idx + 4'd1) < len_q) begin
            shift_d  = shift_q << 1;
            idx_d    = bit_idx + 4'd1;
            strobe_d = 1'b1;
          end else begin
            idx_d   = 4'd0;
            frame_d = frame_cnt + 8'd1;
            gap_d   = 4'd0;
            // With no gap configured the last data bit is also the gap end.
            if (GAP_TICKS == 0) frame_end = 1'b1;
            else                state_d   = GAP;
          end
        end
      end

      GAP: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (gap_q == GAP_LAST) frame_end = 1'b1;
          else                   gap_d     = gap_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        idx_d   = 4'd0;
      end
    endcase

    // Repeat reloads from the private copy so a changed pattern input cannot
    // corrupt a repeating stream.
    if (frame_end) begin
      div_d = '0;
      idx_d = 4'd0;
      if (rpt) begin
        state_d  = SEND;
        shift_d  = pat_q;
        strobe_d = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    // Abort overrides everything, including a coincident frame end. The
    // frame count is left as it was before this cycle.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      div_d    = '0;
      idx_d    = 4'd0;
      gap_d    = 4'd0;
      frame_d  = frame_cnt;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end

    x_d    = (state_d == SEND) ? shift_d[PAT_W-1] : 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      shift_q    <= '0;
      pat_q      <= '0;
      len_q      <= 4'd0;
      gap_q      <= 4'd0;
      bit_idx    <= 4'd0;
      frame_cnt  <= 8'd0;
      x_out      <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      bit_idx    <= idx_d;
      frame_cnt  <= frame_d;
      x_out      <= x_d;
      bit_strobe <= strobe_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
